uart_key_sender: RTL and testbench

- Board-side command source for the cursor/colour UART command protocol: turns push-buttons into the ASCII command bytes the echo/decoder end consumes ('w','a','s','d','c','m','y',' ').
- Synchronises, debounces, edge-detects and auto-repeats the buttons, queues one pending event per source, then drives the uart_fifo transmit side (tx_byte/transmit, back-pressured by tx_fifo_full).
- Sits between board buttons and a uart_fifo instance whose TX pin drives the link toward the command decoder.

---
 rtl/uart_key_sender.sv | 146 ++++++++++++++
 tb/tb_uart_key_sender.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_key_sender.sv
// Push-button front end for the cursor/colour UART command protocol: synchronise, debounce,
// auto-repeat and queue one pending event per button, then feed command bytes to the UART TX FIFO.
module uart_key_sender #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic       btn_color,
    input  logic       tx_fifo_full,
    output logic [7:0] tx_byte,
    output logic       transmit,
    output logic       pending_any,
    output logic [1:0] color_idx
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Bit order everywhere: 0 up, 1 left, 2 down, 3 right, 4 colour (also the issue priority).
    logic [4:0]       w_btn;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [4:0]       r_stable;
    logic [4:0]       r_press;
    logic [CNT_W-1:0] r_db_cnt [5];
    logic [CNT_W-1:0] r_rep_cnt [4];
    logic [4:0]       r_pend;
    logic [4:0]       w_event;
    logic [4:0]       w_grant;
    logic [4:0]       w_clr;
    logic [7:0]       w_byte;
    logic             w_can_issue;

    assign w_btn = {btn_color, btn_right, btn_down, btn_left, btn_up};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_press  <= '0;
            for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_press[i]  <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= sat_inc(r_db_cnt[i]);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Repeat counter is 0 on the press cycle; after the first repeat it reloads so the
    // next hit of REP_DELAY lands exactly REPEAT_RATE cycles later.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) r_rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_stable[i])                  r_rep_cnt[i] <= '0;
                else if (r_rep_cnt[i] == REP_DELAY) r_rep_cnt[i] <= REP_RELOAD;
                else                               r_rep_cnt[i] <= sat_inc(r_rep_cnt[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            w_event[i] = r_press[i] | (r_stable[i] & (r_rep_cnt[i] == REP_DELAY));
        w_event[4] = r_press[4];
    end

    always_comb begin
        w_grant = '0;
        w_byte  = 8'h00;
        if (r_pend[0]) begin
            w_grant[0] = 1'b1;
            w_byte     = 8'h77;
        end else if (r_pend[1]) begin
            w_grant[1] = 1'b1;
            w_byte     = 8'h61;
        end else if (r_pend[2]) begin
            w_grant[2] = 1'b1;
            w_byte     = 8'h73;
        end else if (r_pend[3]) begin
            w_grant[3] = 1'b1;
            w_byte     = 8'h64;
        end else if (r_pend[4]) begin
            w_grant[4] = 1'b1;
            case (color_idx)
                2'd0: w_byte = 8'h63;
                2'd1: w_byte = 8'h6D;
                2'd2: w_byte = 8'h79;
                2'd3: w_byte = 8'h20;
            endcase
        end
    end

    // The !transmit term forces an idle cycle between strobes.
    assign w_can_issue = !transmit && !tx_fifo_full && (|r_pend);
    assign w_clr       = w_can_issue ? w_grant : 5'b0;
    assign pending_any = |r_pend;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pend    <= '0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            color_idx <= 2'd0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_event;
            if (w_can_issue) begin
                transmit <= 1'b1;
                tx_byte  <= w_byte;
                if (w_grant[4]) color_idx <= color_idx + 2'd1;
            end else begin
                transmit <= 1'b0;
                tx_byte  <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_uart_key_sender.sv
// Directed bench for uart_key_sender: behavioural model checked every cycle plus literal
// byte/timing expectations per scenario.
module tb_uart_key_sender;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] btn = '0;
    logic       full = 1'b0;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       pending_any;
    logic [1:0] color_idx;

    uart_key_sender #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(26)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .btn_up(btn[0]), .btn_left(btn[1]), .btn_down(btn[2]), .btn_right(btn[3]),
        .btn_color(btn[4]), .tx_fifo_full(full),
        .tx_byte(tx_byte), .transmit(transmit), .pending_any(pending_any), .color_idx(color_idx)
    );

    initial forever #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int q_b[$];
    int q_c[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qb(input int i);
        return (i < q_b.size()) ? q_b[i] : -1;
    endfunction

    function automatic int qc(input int i);
        return (i < q_c.size()) ? q_c[i] : -1;
    endfunction

    // Behavioural model: state is what holds during the cycle that just ended.
    logic [4:0] s_btn;
    logic       s_full, s_rst;
    int  m_s1[5], m_s2[5], m_stable[5], m_prev[5], m_run[5], press_t[5];
    logic [4:0] m_pend = '0;
    int  m_tx = 0, m_byte = 0, m_cidx = 0;
    int  dir_b[4] = '{8'h77, 8'h61, 8'h73, 8'h64};
    int  col_b[4] = '{8'h63, 8'h6D, 8'h79, 8'h20};

    task automatic model_step();
        logic [4:0] ev;
        int h, win;
        if (s_rst) begin
            for (int i = 0; i < 5; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_prev[i] = 0; m_run[i] = 0;
            end
            m_pend = '0; m_tx = 0; m_byte = 0; m_cidx = 0;
        end else begin
            ev = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_stable[i] == 1 && m_prev[i] == 0) begin
                    ev[i] = 1'b1;
                    press_t[i] = cyc;
                end else if (i < 4 && m_stable[i] == 1) begin
                    h = cyc - press_t[i];
                    if (h == RD || (h > RD && (h - RD) % RR == 0)) ev[i] = 1'b1;
                end
            end
            win = -1;
            if (m_tx == 0 && !s_full)
                for (int i = 4; i >= 0; i--) if (m_pend[i]) win = i;
            if (win >= 0) begin
                m_tx = 1;
                m_byte = (win < 4) ? dir_b[win] : col_b[m_cidx];
                if (win == 4) m_cidx = (m_cidx + 1) % 4;
                m_pend[win] = 1'b0;
            end else begin
                m_tx = 0;
                m_byte = 0;
            end
            m_pend = m_pend | ev;
            for (int i = 0; i < 5; i++) begin
                m_prev[i] = m_stable[i];
                if (m_s2[i] != m_stable[i]) begin
                    if (m_run[i] == DB - 1) begin
                        m_stable[i] = m_s2[i];
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(s_btn[i]);
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
        s_btn = btn; s_full = full; s_rst = RESET;
        @(negedge CLK);
        model_step();
        chk("transmit", int'(transmit), m_tx);
        chk("tx_byte", int'(tx_byte), m_byte);
        chk("pending_any", int'(pending_any), int'(|m_pend));
        chk("color_idx", int'(color_idx), m_cidx);
        if (transmit) begin
            q_b.push_back(int'(tx_byte));
            q_c.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
    endtask

    task automatic clr_log();
        q_b.delete();
        q_c.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int k0;
    int rep_off[6] = '{8, 28, 36, 44, 52, 60};
    int cyc_bytes[5] = '{8'h63, 8'h6D, 8'h79, 8'h20, 8'h63};
    int bp_bytes[4] = '{8'h77, 8'h73, 8'h64, 8'h63};
    int bp_order[5] = '{3, 2, 0, 4, 0};
    bit seen;

    initial begin
        // reset and idle
        tick(3);
        RESET = 1'b0;
        chk("rst_transmit", int'(transmit), 0);
        chk("rst_tx_byte", int'(tx_byte), 0);
        chk("rst_pending", int'(pending_any), 0);
        chk("rst_color_idx", int'(color_idx), 0);
        clr_log();
        tick(100);
        chk("idle_strobes", q_b.size(), 0);

        // clean press of left
        clr_log();
        k0 = cyc;
        btn[1] = 1'b1;
        tick(10);
        btn[1] = 1'b0;
        tick(30);
        chk("left_count", q_b.size(), 1);
        chk("left_byte", qb(0), 8'h61);
        chk("left_latency", qc(0) - k0, 8);

        // bounce rejection
        clr_log();
        for (int j = 0; j < 10; j++) begin
            btn[1] = (j % 2 == 0);
            tick(2);
        end
        btn[1] = 1'b0;
        tick(20);
        chk("bounce_count", q_b.size(), 0);

        // auto-repeat on up
        clr_log();
        k0 = cyc;
        btn[0] = 1'b1;
        tick(60);
        btn[0] = 1'b0;
        tick(40);
        chk("repeat_count", q_b.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk("repeat_byte", qb(j), 8'h77);
            chk("repeat_offset", qc(j) - k0, rep_off[j]);
        end

        // colour held never repeats
        do_reset();
        clr_log();
        btn[4] = 1'b1;
        tick(60);
        btn[4] = 1'b0;
        tick(40);
        chk("color_hold_count", q_b.size(), 1);
        chk("color_hold_byte", qb(0), 8'h63);
        chk("color_hold_idx", int'(color_idx), 1);

        // colour cycling
        do_reset();
        clr_log();
        for (int j = 0; j < 5; j++) begin
            btn[4] = 1'b1;
            tick(10);
            btn[4] = 1'b0;
            tick(15);
        end
        chk("cycle_count", q_b.size(), 5);
        for (int j = 0; j < 5; j++) chk("cycle_byte", qb(j), cyc_bytes[j]);
        chk("cycle_idx", int'(color_idx), 1);

        // back-pressure, priority and merging
        do_reset();
        clr_log();
        full = 1'b1;
        for (int j = 0; j < 5; j++) begin
            btn[bp_order[j]] = 1'b1;
            tick(10);
            btn[bp_order[j]] = 1'b0;
            tick(12);
        end
        tick(10);
        chk("bp_pending", int'(pending_any), 1);
        chk("bp_held_count", q_b.size(), 0);
        full = 1'b0;
        tick(30);
        chk("bp_count", q_b.size(), 4);
        for (int j = 0; j < 4; j++) chk("bp_byte", qb(j), bp_bytes[j]);
        for (int j = 1; j < 4; j++) chk("bp_gap", int'(qc(j) - qc(j - 1) >= 2), 1);

        // reset on the cycle an event is pending
        clr_log();
        btn[1] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 50 && !seen; j++) begin
            @(negedge CLK);
            if (pending_any) seen = 1'b1;
        end
        chk("midrst_pending_seen", int'(seen), 1);
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
        k0 = cyc;
        chk("midrst_no_strobe", q_b.size(), 0);
        tick(20);
        btn[1] = 1'b0;
        tick(20);
        chk("midrst_count", q_b.size(), 1);
        chk("midrst_byte", qb(0), 8'h61);
        chk("midrst_latency", qc(0) - k0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
